stopwatch_timer: RTL

- Parametrised successor of the fixed up-only display timer: a BCD stopwatch/countdown with MM:SS.ff digits.
- Adds start/stop/clear control, preset load, a down-count mode with expiry, an up-count wrap flag and a lap (split) freeze.
- Sits between the frame-rate tick source and the VGA character/digit renderer. o_time keeps the same digit packing as the existing timer, so the renderer is unchanged at default parameters.

---
 rtl/stopwatch_timer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_timer.sv
// BCD stopwatch/countdown (MM:SS.ff) with start/stop/clear, preset load, down-count expiry and up-count wrap.
// Define TIMER_LAP_EN to build the lap (split) register and LAP state; otherwise cmd_lap is ignored.
module stopwatch_timer #(
    parameter int FRAC_HI_MAX  = 6,
    parameter int FRAC_HI_W    = 3,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic                    tick_pls,
    input  logic                    cmd_start,
    input  logic                    cmd_stop,
    input  logic                    cmd_clear,
    input  logic                    cmd_lap,
    input  logic                    mode_down,
    input  logic                    load_valid,
    input  logic [20+FRAC_HI_W-1:0] load_time,
    output logic [20+FRAC_HI_W-1:0] o_time,
    output logic                    o_running,
    output logic                    o_lap_active,
    output logic                    o_expired,
    output logic                    o_wrap
);

    typedef struct packed {
        logic [3:0]           min_t;
        logic [3:0]           min_o;
        logic [3:0]           sec_t;
        logic [3:0]           sec_o;
        logic [FRAC_HI_W-1:0] frac_hi;
        logic [3:0]           frac_lo;
    } time_t;

    typedef enum logic [2:0] {
`ifdef TIMER_LAP_EN
        S_LAP,
`endif
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    localparam logic [FRAC_HI_W-1:0] FH_MAX = FRAC_HI_W'(FRAC_HI_MAX);
    localparam logic [3:0]           MT_MAX = 4'(MIN_TENS_MAX);
    localparam time_t T_MAX = '{min_t: MT_MAX, min_o: 4'd9, sec_t: 4'd5,
                                sec_o: 4'd9, frac_hi: FH_MAX, frac_lo: 4'd9};

    // One BCD digit step; returns {new_digit, carry/borrow out}.
    function automatic logic [4:0] step_dig(input logic [3:0] d, input logic [3:0] mx,
                                            input logic down, input logic ci);
        logic [4:0] r;
        r = {d, 1'b0};
        if (ci) begin
            if (down) r = (d == 4'd0) ? {mx, 1'b1} : {d - 4'd1, 1'b0};
            else      r = (d >= mx)   ? {4'd0, 1'b1} : {d + 4'd1, 1'b0};
        end
        return r;
    endfunction

    function automatic time_t step_time(input time_t t, input logic down);
        time_t n;
        logic  c;
        n = t;
        {n.frac_lo, c} = step_dig(t.frac_lo, 4'd9, down, 1'b1);
        if (c) begin
            if (down) begin
                if (t.frac_hi == '0) n.frac_hi = FH_MAX;
                else begin n.frac_hi = t.frac_hi - 1'b1; c = 1'b0; end
            end else begin
                if (t.frac_hi >= FH_MAX) n.frac_hi = '0;
                else begin n.frac_hi = t.frac_hi + 1'b1; c = 1'b0; end
            end
        end
        {n.sec_o, c} = step_dig(t.sec_o, 4'd9,   down, c);
        {n.sec_t, c} = step_dig(t.sec_t, 4'd5,   down, c);
        {n.min_o, c} = step_dig(t.min_o, 4'd9,   down, c);
        {n.min_t, c} = step_dig(t.min_t, MT_MAX, down, c);
        return n;
    endfunction

    function automatic time_t clamp_time(input time_t t);
        time_t n;
        n.min_t   = (t.min_t   > MT_MAX) ? MT_MAX : t.min_t;
        n.min_o   = (t.min_o   > 4'd9)   ? 4'd9   : t.min_o;
        n.sec_t   = (t.sec_t   > 4'd5)   ? 4'd5   : t.sec_t;
        n.sec_o   = (t.sec_o   > 4'd9)   ? 4'd9   : t.sec_o;
        n.frac_hi = (t.frac_hi > FH_MAX) ? FH_MAX : t.frac_hi;
        n.frac_lo = (t.frac_lo > 4'd9)   ? 4'd9   : t.frac_lo;
        return n;
    endfunction

    state_t state, state_nx;
    time_t  cnt, cnt_nx, ld_clamped, cnt_step;
    logic   mode_dn, mode_nx;
    logic   wrap_q, wrap_nx;
    logic   running, tick;
`ifdef TIMER_LAP_EN
    time_t  lap_q, lap_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mode_dn <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef TIMER_LAP_EN
            lap_q   <= '0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            mode_dn <= mode_nx;
            wrap_q  <= wrap_nx;
`ifdef TIMER_LAP_EN
            lap_q   <= lap_nx;
`endif
        end
    end

    // Commands resolve in priority order; a tick only advances when no higher command was accepted.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        mode_nx    = mode_dn;
        wrap_nx    = 1'b0;
        tick       = tick_en && tick_pls;
        ld_clamped = clamp_time(load_time);
        cnt_step   = step_time(cnt, mode_dn);
`ifdef TIMER_LAP_EN
        lap_nx     = lap_q;
        running    = (state == S_RUN) || (state == S_LAP);
`else
        running    = (state == S_RUN);
`endif
        if (cmd_clear) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
`ifdef TIMER_LAP_EN
            lap_nx   = '0;
`endif
        end else if (load_valid && !running) begin
            cnt_nx   = ld_clamped;
            state_nx = (ld_clamped == '0) ? S_IDLE : S_PAUSE;
        end else if (cmd_stop && running) begin
            state_nx = S_PAUSE;
        end else if (cmd_start && (state == S_IDLE || state == S_PAUSE)) begin
            mode_nx  = mode_down;
            state_nx = (mode_down && cnt == '0) ? S_EXPIRED : S_RUN;
        end else begin
`ifdef TIMER_LAP_EN
            if (cmd_lap && state == S_RUN) begin
                lap_nx   = cnt;
                state_nx = S_LAP;
            end else if (cmd_lap && state == S_LAP) begin
                state_nx = S_RUN;
            end
`endif
            if (running && tick) begin
                cnt_nx = cnt_step;
                if (!mode_dn && cnt == T_MAX) wrap_nx = 1'b1;
                if (mode_dn && cnt_step == '0) state_nx = S_EXPIRED;
            end
        end
    end

    assign o_running = running;
    assign o_expired = (state == S_EXPIRED);
    assign o_wrap    = wrap_q;
`ifdef TIMER_LAP_EN
    assign o_lap_active = (state == S_LAP);
    assign o_time       = (state == S_LAP) ? lap_q : cnt;
`else
    assign o_lap_active = 1'b0;
    assign o_time       = cnt;
`endif

endmodule
